// File: rtl/ddr4_cmd_timer_if.sv
// Instruction path between the SoftMC dispatcher, the timing gate and the decoder.
// The dispatcher owns in_valid/in_instr; the gate drives the handshake return and the issue side.
interface ddr4_cmd_timer_if #(
    parameter int BANK_WIDTH = 3
);
    localparam int NB = 2 ** BANK_WIDTH;

    // Handshake: an instruction transfers on a cycle where in_valid && in_ready are both high.
    // in_valid and in_instr must not change until that transfer; in_ready may depend on in_instr.
    logic          in_valid;
    logic [31:0]   in_instr;
    logic          in_ready;
    logic          out_en;
    logic [31:0]   out_instr;
    logic          err;
    logic [1:0]    err_code;
    logic [NB-1:0] open_banks;

    modport master (
        output in_valid, in_instr,
        input  in_ready, out_en, out_instr, err, err_code, open_banks
    );

    modport slave (
        input  in_valid, in_instr,
        output in_ready, out_en, out_instr, err, err_code, open_banks
    );
endinterface

// File: rtl/ddr4_cmd_timer.sv
// DDR4 command timing gate: holds each SoftMC instruction until tRCD/tRAS/tRP/tRRD/tRFC allow it,
// tracks per-bank open state, issues legal commands and drops protocol-illegal ones with an error code.
module ddr4_cmd_timer #(
    parameter int BANK_WIDTH = 3,
    parameter int TRCD       = 4,
    parameter int TRAS       = 10,
    parameter int TRP        = 4,
    parameter int TRRD       = 2,
    parameter int TRFC       = 32,
    parameter int CNT_WIDTH  = 8,
    parameter int CS_OFFSET  = 27,
    parameter int RAS_OFFSET = 26,
    parameter int CAS_OFFSET = 25,
    parameter int WE_OFFSET  = 24,
    parameter int ROW_OFFSET = 16
) (
    input logic            clk,
    input logic            rst,
    ddr4_cmd_timer_if.slave bus
);
    localparam int NB = 2 ** BANK_WIDTH;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    // A timer loaded with T-1 on the accept at cycle t reads zero again at cycle t+T.
    localparam cnt_t L_RCD = cnt_t'(TRCD - 1);
    localparam cnt_t L_RAS = cnt_t'(TRAS - 1);
    localparam cnt_t L_RP  = cnt_t'(TRP - 1);
    localparam cnt_t L_RRD = cnt_t'(TRRD - 1);
    localparam cnt_t L_RFC = cnt_t'(TRFC - 1);
    localparam cnt_t ONE   = cnt_t'(1);

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_PRE, CMD_RD, CMD_WR, CMD_REF
    } cmd_t;

    typedef enum logic {
        BANK_CLOSED = 1'b0,
        BANK_OPEN   = 1'b1
    } bank_state_t;

    bank_state_t r_bank_state   [NB];
    bank_state_t w_bank_state_nx[NB];
    cnt_t        r_rcd [NB];
    cnt_t        r_ras [NB];
    cnt_t        r_rp  [NB];
    cnt_t        r_rrd;
    cnt_t        r_rfc;

    logic        r_out_en;
    logic [31:0] r_out_instr;
    logic        r_err;
    logic [1:0]  r_err_code;

    cmd_t                  w_cmd;
    logic [2:0]            w_code;
    logic [BANK_WIDTH-1:0] w_bank;
    logic                  w_rp_all_done;
    logic                  w_any_open;
    logic                  w_rfc_done;
    logic                  w_timing_ok;
    logic                  w_proto_err;
    logic [1:0]            w_err_code;
    logic                  w_accept;
    logic                  w_issue;
    logic [NB-1:0]         w_sel;
    logic [NB-1:0]         w_act_sel;
    logic [NB-1:0]         w_pre_sel;
    logic [NB-1:0]         w_open;

    // Command bits are active-low; CS high deselects the device, which makes it a NOP.
    always_comb begin
        w_code = {bus.in_instr[RAS_OFFSET], bus.in_instr[CAS_OFFSET], bus.in_instr[WE_OFFSET]};
        w_bank = bus.in_instr[ROW_OFFSET +: BANK_WIDTH];
        w_cmd  = CMD_NOP;
        if (!bus.in_instr[CS_OFFSET]) begin
            case (w_code)
                3'b011:  w_cmd = CMD_ACT;
                3'b010:  w_cmd = CMD_PRE;
                3'b101:  w_cmd = CMD_RD;
                3'b100:  w_cmd = CMD_WR;
                3'b001:  w_cmd = CMD_REF;
                default: w_cmd = CMD_NOP;
            endcase
        end
    end

    always_comb begin
        w_rp_all_done = 1'b1;
        w_any_open    = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (r_rp[b] != '0) w_rp_all_done = 1'b0;
            if (r_bank_state[b] == BANK_OPEN) w_any_open = 1'b1;
            w_open[b] = (r_bank_state[b] == BANK_OPEN);
        end
    end

    // Protocol errors are judged only after timing clears, so an illegal command still waits its turn.
    always_comb begin
        w_rfc_done  = (r_rfc == '0);
        w_timing_ok = 1'b1;
        w_proto_err = 1'b0;
        w_err_code  = 2'd0;
        case (w_cmd)
            CMD_ACT: begin
                w_timing_ok = (r_rp[w_bank] == '0) && (r_rrd == '0) && w_rfc_done;
                if (r_bank_state[w_bank] == BANK_OPEN) begin
                    w_proto_err = 1'b1;
                    w_err_code  = 2'd2;
                end
            end
            CMD_PRE: begin
                w_timing_ok = ((r_bank_state[w_bank] == BANK_CLOSED) || (r_ras[w_bank] == '0))
                              && w_rfc_done;
            end
            CMD_RD, CMD_WR: begin
                w_timing_ok = (r_rcd[w_bank] == '0) && w_rfc_done;
                if (r_bank_state[w_bank] == BANK_CLOSED) begin
                    w_proto_err = 1'b1;
                    w_err_code  = 2'd1;
                end
            end
            CMD_REF: begin
                w_timing_ok = w_rp_all_done && w_rfc_done;
                if (w_any_open) begin
                    w_proto_err = 1'b1;
                    w_err_code  = 2'd3;
                end
            end
            default: w_timing_ok = 1'b1;
        endcase
    end

    assign w_accept  = bus.in_valid && w_timing_ok;
    assign w_issue   = w_accept && !w_proto_err;
    assign w_sel     = w_issue ? (NB'(1) << w_bank) : '0;
    assign w_act_sel = w_sel & {NB{w_cmd == CMD_ACT}};
    assign w_pre_sel = w_sel & {NB{w_cmd == CMD_PRE}};

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            w_bank_state_nx[b] = r_bank_state[b];
            if (w_act_sel[b]) w_bank_state_nx[b] = BANK_OPEN;
            if (w_pre_sel[b]) w_bank_state_nx[b] = BANK_CLOSED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) r_bank_state[b] <= BANK_CLOSED;
        end else begin
            for (int b = 0; b < NB; b++) r_bank_state[b] <= w_bank_state_nx[b];
        end
    end

    // Saturating down-counters; a fresh trigger reloads even while the previous spacing is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                r_rcd[b] <= '0;
                r_ras[b] <= '0;
                r_rp[b]  <= '0;
            end
            r_rrd <= '0;
            r_rfc <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (w_act_sel[b]) begin
                    r_rcd[b] <= L_RCD;
                    r_ras[b] <= L_RAS;
                end else begin
                    if (r_rcd[b] != '0) r_rcd[b] <= r_rcd[b] - ONE;
                    if (r_ras[b] != '0) r_ras[b] <= r_ras[b] - ONE;
                end
                if (w_pre_sel[b])       r_rp[b] <= L_RP;
                else if (r_rp[b] != '0) r_rp[b] <= r_rp[b] - ONE;
            end
            if (w_issue && w_cmd == CMD_ACT) r_rrd <= L_RRD;
            else if (r_rrd != '0)            r_rrd <= r_rrd - ONE;
            if (w_issue && w_cmd == CMD_REF) r_rfc <= L_RFC;
            else if (r_rfc != '0)            r_rfc <= r_rfc - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_en    <= 1'b0;
            r_out_instr <= '0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_out_en   <= w_issue;
            r_err      <= w_accept && w_proto_err;
            r_err_code <= (w_accept && w_proto_err) ? w_err_code : 2'd0;
            if (w_issue) r_out_instr <= bus.in_instr;
        end
    end

    assign bus.in_ready   = w_timing_ok;
    assign bus.out_en     = r_out_en;
    assign bus.out_instr  = r_out_instr;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;
    assign bus.open_banks = w_open;
endmodule

// File: tb/tb_ddr4_cmd_timer.sv
// Bench for ddr4_cmd_timer: directed scenarios then random traffic, checked every cycle against
// a model that records accept times and tests the spacing rules with plain arithmetic.
module tb_ddr4_cmd_timer;
    localparam int BW         = 3;
    localparam int NB         = 2 ** BW;
    localparam int TRCD       = 4;
    localparam int TRAS       = 10;
    localparam int TRP        = 4;
    localparam int TRRD       = 2;
    localparam int TRFC       = 32;
    localparam int CS_OFFSET  = 27;
    localparam int RAS_OFFSET = 26;
    localparam int CAS_OFFSET = 25;
    localparam int WE_OFFSET  = 24;
    localparam int ROW_OFFSET = 16;
    localparam int K_NOP = 0, K_ACT = 1, K_PRE = 2, K_RDWR = 3, K_REF = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ddr4_cmd_timer_if #(.BANK_WIDTH(BW)) bus ();

    ddr4_cmd_timer #(
        .BANK_WIDTH(BW), .TRCD(TRCD), .TRAS(TRAS), .TRP(TRP), .TRRD(TRRD), .TRFC(TRFC),
        .CNT_WIDTH(8), .CS_OFFSET(CS_OFFSET), .RAS_OFFSET(RAS_OFFSET),
        .CAS_OFFSET(CAS_OFFSET), .WE_OFFSET(WE_OFFSET), .ROW_OFFSET(ROW_OFFSET)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    longint        mcyc;
    longint        t_act [NB];
    longint        t_pre [NB];
    longint        t_act_any;
    longint        t_ref;
    logic [NB-1:0] m_open;
    bit            pend_en;
    bit            pend_err;
    logic [1:0]    pend_code;
    logic [31:0]   last_issued;
    logic [31:0]   exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    function automatic void m_clear();
        for (int b = 0; b < NB; b++) begin
            t_act[b] = -1000;
            t_pre[b] = -1000;
        end
        t_act_any   = -1000;
        t_ref       = -1000;
        m_open      = '0;
        pend_en     = 0;
        pend_err    = 0;
        pend_code   = 2'd0;
        last_issued = '0;
        mcyc        = 0;
        exp_q.delete();
    endfunction

    function automatic logic [31:0] mk(input bit cs, input logic [2:0] code, input int bank);
        logic [31:0] x;
        x = $urandom;
        x[CS_OFFSET]  = cs;
        x[RAS_OFFSET] = code[2];
        x[CAS_OFFSET] = code[1];
        x[WE_OFFSET]  = code[0];
        x[ROW_OFFSET +: BW] = BW'(bank);
        return x;
    endfunction

    function automatic int kind(input logic [31:0] x);
        logic [2:0] c;
        c = {x[RAS_OFFSET], x[CAS_OFFSET], x[WE_OFFSET]};
        if (x[CS_OFFSET]) return K_NOP;
        case (c)
            3'b011:         return K_ACT;
            3'b010:         return K_PRE;
            3'b101, 3'b100: return K_RDWR;
            3'b001:         return K_REF;
            default:        return K_NOP;
        endcase
    endfunction

    function automatic int bank_of(input logic [31:0] x);
        return int'(x[ROW_OFFSET +: BW]);
    endfunction

    // A command may be accepted at cycle now if every relevant earlier accept is at least T cycles back.
    function automatic bit m_ready(input logic [31:0] x);
        int  k;
        int  b;
        bit  rfc_ok;
        bit  all_rp;
        k = kind(x);
        b = bank_of(x);
        rfc_ok = (mcyc >= t_ref + TRFC);
        all_rp = 1;
        for (int i = 0; i < NB; i++) if (mcyc < t_pre[i] + TRP) all_rp = 0;
        case (k)
            K_ACT:   return (mcyc >= t_pre[b] + TRP) && (mcyc >= t_act_any + TRRD) && rfc_ok;
            K_PRE:   return (!m_open[b] || (mcyc >= t_act[b] + TRAS)) && rfc_ok;
            K_RDWR:  return (mcyc >= t_act[b] + TRCD) && rfc_ok;
            K_REF:   return all_rp && rfc_ok;
            default: return 1;
        endcase
    endfunction

    function automatic void m_accept(input logic [31:0] x);
        int         k;
        int         b;
        bit         e;
        logic [1:0] c;
        k = kind(x);
        b = bank_of(x);
        e = 0;
        c = 2'd0;
        if (k == K_ACT && m_open[b])     begin e = 1; c = 2'd2; end
        if (k == K_RDWR && !m_open[b])   begin e = 1; c = 2'd1; end
        if (k == K_REF && m_open != '0)  begin e = 1; c = 2'd3; end
        if (e) begin
            pend_err  = 1;
            pend_code = c;
            return;
        end
        pend_en = 1;
        exp_q.push_back(x);
        case (k)
            K_ACT: begin t_act[b] = mcyc; t_act_any = mcyc; m_open[b] = 1'b1; end
            K_PRE: begin t_pre[b] = mcyc; m_open[b] = 1'b0; end
            K_REF: t_ref = mcyc;
            default: ;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, mcyc, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Entered and left at a falling edge: check the outputs due from the last accept, drive, then clock.
    task automatic tick(input bit valid, input logic [31:0] instr, output bit acc);
        check_eq("out_en", 32'(bus.out_en), 32'(pend_en));
        if (pend_en) last_issued = exp_q.pop_front();
        check_eq("out_instr", bus.out_instr, last_issued);
        check_eq("err", 32'(bus.err), 32'(pend_err));
        check_eq("err_code", 32'(bus.err_code), pend_err ? 32'(pend_code) : 32'd0);
        check_eq("open_banks", 32'(bus.open_banks), 32'(m_open));
        bus.in_valid = valid;
        bus.in_instr = instr;
        #1;
        acc      = 0;
        pend_en  = 0;
        pend_err = 0;
        if (valid) begin
            check_eq("in_ready", 32'(bus.in_ready), 32'(m_ready(instr)));
            acc = bus.in_ready;
            if (acc) m_accept(instr);
        end
        @(posedge clk);
        mcyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(0, '0, acc);
    endtask

    task automatic send(input logic [31:0] instr, output longint t_acc);
        bit acc;
        acc = 0;
        for (int n = 0; n < 200; n++) begin
            tick(1, instr, acc);
            if (acc) begin
                t_acc = mcyc - 1;
                return;
            end
        end
        check_eq("accept_timeout", 32'(acc), 32'd1);
        t_acc = -1;
    endtask

    task automatic do_reset();
        bus.in_valid = 0;
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        m_clear();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        longint t0;
        longint t;
        logic [31:0] x;
        int k;
        bus.in_valid = 0;
        bus.in_instr = '0;
        m_clear();
        do_reset();

        // reset values, and RD to closed bank 5 is ready-and-drop
        idle(1);
        t0 = mcyc;
        send(mk(0, 3'b101, 5), t);
        check_eq("rd_closed_lat", 32'(t - t0), 32'd0);
        check_eq("rd_closed_err", 32'(bus.err), 32'd1);
        check_eq("rd_closed_code", 32'(bus.err_code), 32'd1);
        check_eq("rd_closed_open", 32'(bus.open_banks), 32'd0);
        idle(1);

        // tRCD
        do_reset();
        send(mk(0, 3'b011, 2), t0);
        send(mk(0, 3'b101, 2), t);
        check_eq("trcd_lat", 32'(t - t0), 32'd4);
        check_eq("trcd_out_en", 32'(bus.out_en), 32'd1);
        check_eq("trcd_open", 32'(bus.open_banks), 32'h04);
        idle(1);

        // tRAS then tRP on the same bank
        do_reset();
        send(mk(0, 3'b011, 0), t0);
        send(mk(0, 3'b010, 0), t);
        check_eq("tras_lat", 32'(t - t0), 32'd10);
        send(mk(0, 3'b011, 0), t);
        check_eq("trp_lat", 32'(t - t0), 32'd14);
        idle(1);

        // tRRD, then ACT to an open bank
        do_reset();
        send(mk(0, 3'b011, 0), t0);
        send(mk(0, 3'b011, 1), t);
        check_eq("trrd_lat", 32'(t - t0), 32'd2);
        send(mk(0, 3'b011, 0), t);
        check_eq("act_open_err", 32'(bus.err), 32'd1);
        check_eq("act_open_code", 32'(bus.err_code), 32'd2);
        check_eq("act_open_en", 32'(bus.out_en), 32'd0);
        idle(1);

        // tRFC, then REF with bank 3 open
        do_reset();
        send(mk(0, 3'b001, 0), t0);
        send(mk(0, 3'b011, 0), t);
        check_eq("trfc_lat", 32'(t - t0), 32'd32);
        send(mk(0, 3'b011, 3), t);
        send(mk(0, 3'b001, 0), t);
        check_eq("ref_open_err", 32'(bus.err), 32'd1);
        check_eq("ref_open_code", 32'(bus.err_code), 32'd3);
        idle(1);

        // back-to-back NOPs, then asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            t0 = mcyc;
            send(mk(1, 3'($urandom_range(0, 7)), i), t);
            check_eq("nop_lat", 32'(t - t0), 32'd0);
        end
        send(mk(0, 3'b011, 1), t);
        idle(3);
        send(mk(0, 3'b011, 4), t);
        rst = 1;
        #1;
        check_eq("rst_open", 32'(bus.open_banks), 32'd0);
        check_eq("rst_out_en", 32'(bus.out_en), 32'd0);
        check_eq("rst_out_instr", bus.out_instr, 32'd0);
        m_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        t0 = mcyc;
        send(mk(0, 3'b010, 1), t);
        check_eq("rst_pre_lat", 32'(t - t0), 32'd0);
        idle(1);

        // random traffic
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            k = $urandom_range(0, 11);
            case (k)
                0, 1, 2:    x = mk(0, 3'b011, $urandom_range(0, NB - 1));
                3, 4, 5, 6: x = mk(0, 3'b010, $urandom_range(0, NB - 1));
                7:          x = mk(0, 3'b101, $urandom_range(0, NB - 1));
                8:          x = mk(0, 3'b100, $urandom_range(0, NB - 1));
                9:          x = mk(0, 3'b001, $urandom_range(0, NB - 1));
                10:         x = mk(1, 3'($urandom_range(0, 7)), $urandom_range(0, NB - 1));
                default: begin
                    case ($urandom_range(0, 2))
                        0:       x = mk(0, 3'b000, $urandom_range(0, NB - 1));
                        1:       x = mk(0, 3'b110, $urandom_range(0, NB - 1));
                        default: x = mk(0, 3'b111, $urandom_range(0, NB - 1));
                    endcase
                end
            endcase
            send(x, t);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
